// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/grant bundle between the clients and the shared interval timer
// master drives req, duration and abort; slave drives grant, busy, done and count
interface timer_arbiter_if #(
    parameter int NUM_REQ            = 4,
    parameter int COUNTER_BIT_NUMBER = 8
);
    logic [NUM_REQ-1:0]                    req;
    logic [NUM_REQ*COUNTER_BIT_NUMBER-1:0] duration;
    logic                                  abort;
    logic [NUM_REQ-1:0]                    grant;
    logic                                  busy;
    logic [NUM_REQ-1:0]                    done;
    logic [COUNTER_BIT_NUMBER-1:0]         count;
    modport master (output req, duration, abort, input grant, busy, done, count);
    modport slave  (input req, duration, abort, output grant, busy, done, count);
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner selection for one shared interval counter
// clk, reset_n (sync, active low); bus.slave: req/duration/abort in, grant/busy/done/count out
module timer_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int COUNTER_BIT_NUMBER = 8
) (
    input logic           clk,
    input logic           reset_n,
    timer_arbiter_if.slave bus
);
    localparam int W  = COUNTER_BIT_NUMBER;
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d, win;
    logic [W-1:0]       limit_q, limit_d, count_q, count_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic               found;
    int                 idx;
    // first asserted request at or after last+1, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_q) + 1 + i) % NUM_REQ;
            if (!found && bus.req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        limit_d = limit_q;
        count_d = count_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d = RUN;
                limit_d = bus.duration[win*W +: W];
                count_d = '0;
                grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                last_d  = win;
            end
            RUN: if (bus.abort) begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end else if (count_q == limit_q) begin
                state_d = DONE;
                done_d  = grant_q;
            end else begin
                count_d = count_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            limit_q <= '0;
            count_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            limit_q <= limit_d;
            count_q <= count_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end
    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.count = count_q;
endmodule
